pwm_decoder: RTL

Measures an incoming PWM waveform, like the one driving the motor, and recovers its 2-bit speed level, so it acts as the receive end of the motor PWM link. It measures the period and high time between consecutive rising edges and classifies the duty cycle into the 25/50/75/100 % levels. It also detects waveforms stuck high or stuck low. It sits on the feedback or observation side of the motor path and feeds status and self-check logic.

---
 rtl/pwm_decoder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pwm_decoder.sv
// Purpose : recovers the 2-bit speed level of a PWM waveform by measuring period and high time between rising edges; flags stuck inputs.
// Latency : outputs and valid register one clock after the synchronized rising-edge strobe (3 clocks after pwm_in is first sampled high).
// Backpress: none; valid is a one-cycle strobe that the consumer must take when it appears.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset (clears synchronizer too)
//   pwm_in   asynchronous PWM input
//   speed    decoded level 0..3 = 25/50/75/100 %
//   duty_hi  high-cycle count of the last completed measurement
//   period   cycle count of the last completed measurement
//   valid    one-cycle pulse when speed/duty_hi/period/stopped update
//   stopped  input stuck low, set by the last timeout
module pwm_decoder #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = (1 << (CNT_W + 1)) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [1:0]       speed,
  output logic [CNT_W:0]   duty_hi,
  output logic [CNT_W:0]   period,
  output logic             valid,
  output logic             stopped
);

  localparam int CW = CNT_W + 1;   // counter width
  localparam int PW = CW + 3;      // product width: 8*hi and 7*per fit without truncation

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t        state;
  logic [1:0]    sync_q;    // two-flop synchronizer; sync_q[1] is s
  logic          s_d;       // s delayed one cycle for edge detection
  logic          s;
  logic          rise;
  logic [CW-1:0] per;
  logic [CW-1:0] hi;

  logic [PW-1:0] hi_x8;
  logic [PW-1:0] per_x7;
  logic [PW-1:0] per_x5;
  logic [PW-1:0] per_x3;
  logic [1:0]    speed_nxt;

  assign s    = sync_q[1];
  assign rise = s & ~s_d;

  // Duty classification against the midpoints 87.5 / 62.5 / 37.5 %,
  // done as cross-multiplication so no divider is needed.
  always_comb begin
    hi_x8     = {hi, 3'b000};
    per_x7    = {3'b000, per} * PW'(7);
    per_x5    = {3'b000, per} * PW'(5);
    per_x3    = {3'b000, per} * PW'(3);
    speed_nxt = 2'd0;
    if (hi_x8 >= per_x7) begin
      speed_nxt = 2'd3;
    end else if (hi_x8 >= per_x5) begin
      speed_nxt = 2'd2;
    end else if (hi_x8 >= per_x3) begin
      speed_nxt = 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      s_d     <= 1'b0;
      state   <= IDLE;
      per     <= '0;
      hi      <= '0;
      speed   <= 2'd0;
      duty_hi <= '0;
      period  <= '0;
      valid   <= 1'b0;
      stopped <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
      s_d    <= s;
      valid  <= 1'b0;

      case (state)
        // Waiting for an edge to align to; nothing is reported from here.
        IDLE: begin
          if (rise) begin
            per   <= CW'(1);
            hi    <= CW'(1);
            state <= MEAS;
          end
        end

        MEAS: begin
          // A rise always completes the period, even when it lands on the
          // timeout count.
          if (rise) begin
            period  <= per;
            duty_hi <= hi;
            speed   <= speed_nxt;
            stopped <= 1'b0;
            valid   <= 1'b1;
            per     <= CW'(1);
            hi      <= CW'(1);
          end else if (per == TO_VAL) begin
            // No edge for too long: the level now present says which way
            // the line is stuck.
            period  <= TO_VAL;
            duty_hi <= hi;
            valid   <= 1'b1;
            state   <= IDLE;
            if (s) begin
              speed   <= 2'd3;
              stopped <= 1'b0;
            end else begin
              speed   <= 2'd0;
              stopped <= 1'b1;
            end
          end else begin
            if (per != CNT_MAX) begin
              per <= per + CW'(1);
            end
            if (s && (hi != CNT_MAX)) begin
              hi <= hi + CW'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
